inst_load_arbiter: RTL and testbench
====================================

// Module: inst_load_arbiter
// PURPOSE
//  Owns the single port of the instruction RAM and shares it between the fetch stage (reads) and
//  the Ethernet program loader (writes). Sequences a program load: stalls fetch, drains in-flight
//  reads, writes the streamed words, appends an all-zero end-of-program word, then restarts fetch at PC 0.
// PARAMETERS
//  INST_W    64    instruction word width (bits)
//  DEPTH     1024  RAM entries; ADDR_W = $clog2(DEPTH)
//  RD_LAT    2     RAM read latency in cycles (HIGH_PERFORMANCE); drain length
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       synchronous reset, active-low
//  ld_start       in   1       pulse: begin new program load
//  ld_valid       in   1       loader word valid
//  ld_ready       out  1       arbiter accepts word (transfer = ld_valid & ld_ready)
//  ld_data        in   INST_W  instruction word
//  ld_last        in   1       qualifies final word of program
//  ld_csum        in   INST_W  expected XOR checksum, sampled with last word (used only with macro)
//  fetch_addr     in   ADDR_W  fetch PC
//  fetch_grant    out  1       fetch owns RAM; 0 = fetch must stall
//  fetch_restart  out  1       1-cycle pulse: fetch resets PC to 0
//  prog_valid     out  1       a complete, error-free program is resident
//  load_error     out  1       sticky until next ld_start: overflow or checksum fail
//  load_count     out  ADDR_W+1  words written by last load (excl. terminator)
//  ram_en         out  1       RAM enable
//  ram_we         out  1       RAM write enable
//  ram_addr       out  ADDR_W  RAM address
//  ram_din        out  INST_W  RAM write data
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, prog_valid=1 (RAM holds init image), fetch_grant=1,
//   ld_ready=0, fetch_restart=0, load_error=0, load_count=0, ram_we=0, wr_ptr=0, drain_cnt=0.
//  FSM: IDLE -> DRAIN -> LOAD -> TERM -> DONE -> IDLE; also LOAD -> SKIP -> DONE.
//  IDLE: ram_addr=fetch_addr, ram_we=0, ram_en=1, fetch_grant=prog_valid. ld_start -> DRAIN,
//   fetch_grant=0 next cycle, prog_valid=0, load_error=0, wr_ptr=0, load_count=0.
//  DRAIN: RD_LAT cycles, ram_we=0, ld_ready=0 (in-flight reads complete); then LOAD.
//  LOAD: ld_ready=1; each transfer writes ld_data at wr_ptr (ram_we=1 same cycle), wr_ptr++,
//   load_count++. Transfer with ld_last -> TERM. Transfer at wr_ptr=DEPTH-1 without ld_last:
//   word written, load_error=1, -> SKIP.
//  TERM: if wr_ptr<DEPTH write 0 at wr_ptr (1 cycle); if wr_ptr==DEPTH (exact fill) no write. -> DONE.
//  SKIP: ld_ready=1, words consumed and discarded (ram_we=0) until ld_last transfer -> DONE.
//  DONE: 1 cycle; prog_valid=~load_error; fetch_restart=~load_error; -> IDLE.
//   fetch_grant rises the cycle after DONE only if prog_valid.
//  ld_start outside IDLE ignored. ld_valid in IDLE/DRAIN not accepted (ld_ready=0).
//  Zero-length load impossible: ld_last rides a data word; 1-word program -> word@0, 0@1.
//  rst_n low mid-load: immediate return to reset values; partially written RAM retained but
//   prog_valid=1 reflects assumed reload by software -- loader must restart load after reset.
//  Widths: wr_ptr ADDR_W+1 bits so DEPTH is representable; no wrap-around.
// CONFIGURATION
//  LOAD_CHECKSUM_EN defined: running XOR of every accepted LOAD word (cleared on ld_start);
//   on ld_last transfer, (acc ^ ld_data) != ld_csum -> load_error=1, prog_valid stays 0, no
//   fetch_restart. Terminator still written. Checksum not evaluated in SKIP.
//  Not defined: ld_csum ignored; no accumulator; load_error only from overflow.
// TESTING
//  1 reset, fetch_addr=5 -> ram_addr=5, ram_we=0, fetch_grant=1, prog_valid=1.
//  2 ld_start, 3 words A,B,C(last) back-to-back -> grant=0 for drain+load, writes A@0,B@1,C@2,
//    0@3, fetch_restart pulse once, load_count=3, prog_valid=1.
//  3 DEPTH=8, 10 words, last on 10th -> words 0..7 written, 8,9 dropped, load_error=1,
//    prog_valid=0, fetch_grant stays 0, no fetch_restart.
//  4 DEPTH=8, exactly 8 words -> no terminator write, load_error=0, load_count=8.
//  5 ld_valid gapped (1 of 3 cycles) + ld_start during LOAD -> stalls tolerated, ld_start ignored.
//  6 LOAD_CHECKSUM_EN: words 1,2,3 with ld_csum=0 -> ok; ld_csum=1 -> load_error=1, prog_valid=0.

Source files
------------

// File: rtl/inst_load_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_load_arbiter_if
//  Description : Bundles the signals around the instruction-RAM arbiter.
//                This covers the program-loader stream, the fetch-stage
//                control, the load status and the single RAM port.
//                slave  = arbiter side
//                master = loader / fetch / RAM side
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_load_arbiter_if #(
  parameter int INST_W = 64,
  parameter int DEPTH  = 1024
);
  localparam int c_ADDR_W = $clog2(DEPTH);

  // Program loader stream
  logic                ld_start;
  logic                ld_valid;
  logic                ld_ready;
  logic [INST_W-1:0]   ld_data;
  logic                ld_last;
  logic [INST_W-1:0]   ld_csum;

  // Fetch stage
  logic [c_ADDR_W-1:0] fetch_addr;
  logic                fetch_grant;
  logic                fetch_restart;

  // Load status
  logic                prog_valid;
  logic                load_error;
  logic [c_ADDR_W:0]   load_count;

  // Instruction RAM port
  logic                ram_en;
  logic                ram_we;
  logic [c_ADDR_W-1:0] ram_addr;
  logic [INST_W-1:0]   ram_din;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, ld_csum, fetch_addr,
    output ld_ready, fetch_grant, fetch_restart, prog_valid, load_error,
           load_count, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, ld_csum, fetch_addr,
    input  ld_ready, fetch_grant, fetch_restart, prog_valid, load_error,
           load_count, ram_en, ram_we, ram_addr, ram_din
  );
endinterface
`default_nettype wire

// File: rtl/inst_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inst_load_arbiter
//  Description : Owns the single instruction-RAM port and shares it between
//                the fetch stage (reads) and the program loader (writes).
//                A program load runs through these steps:
//                  1. stall fetch
//                  2. drain in-flight reads
//                  3. write the streamed words
//                  4. append an all-zero end-of-program word
//                  5. restart fetch at PC 0
//  Options     : define LOAD_CHECKSUM_EN to verify a running XOR checksum
//                of the loaded words against ld_csum on the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_load_arbiter #(
  parameter int INST_W = 64,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_load_arbiter_if.slave    bus
);

  localparam int c_ADDR_W  = $clog2(DEPTH);
  localparam int c_WR_W    = c_ADDR_W + 1;
  localparam int c_DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  // The write pointer is one bit wider than the address so that a full
  // RAM (pointer == DEPTH) can be distinguished from an empty one.
  localparam logic [c_WR_W-1:0]    c_DEPTH      = c_WR_W'(DEPTH);
  localparam logic [c_WR_W-1:0]    c_DEPTH_M1   = c_WR_W'(DEPTH - 1);
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_LOAD  = 3'd2,
    S_TERM  = 3'd3,
    S_SKIP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_prog_valid;
  logic                 r_load_error;
  logic [c_WR_W-1:0]    r_load_count;
  logic [c_WR_W-1:0]    r_wr_ptr;
  logic [c_DRAIN_W-1:0] r_drain_cnt;

  logic                 w_ld_ready;
  logic                 w_xfer;
  logic                 w_start;
  logic                 w_csum_bad;
  logic                 w_fetch_grant;
  logic                 w_fetch_restart;
  logic                 w_ram_en;
  logic                 w_ram_we;
  logic [c_ADDR_W-1:0]  w_ram_addr;
  logic [INST_W-1:0]    w_ram_din;

  // A load request is honoured only while idle.
  assign w_start = (r_state == S_IDLE) && bus.ld_start;

  // A loader word changes hands only in the states that present ld_ready.
  assign w_xfer  = bus.ld_valid && w_ld_ready;

`ifdef LOAD_CHECKSUM_EN
  logic [INST_W-1:0] r_csum_acc;

  // Running XOR of every word accepted in LOAD, restarted with each load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_csum_acc <= '0;
    end else if (w_start) begin
      r_csum_acc <= '0;
    end else if ((r_state == S_LOAD) && w_xfer) begin
      r_csum_acc <= r_csum_acc ^ bus.ld_data;
    end
  end

  // The last word is folded in before comparing against the expected value.
  assign w_csum_bad = ((r_csum_acc ^ bus.ld_data) != bus.ld_csum);
`else
  assign w_csum_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state RAM / handshake outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_ld_ready      = 1'b0;
    w_fetch_grant   = 1'b0;
    w_fetch_restart = 1'b0;
    w_ram_en        = 1'b0;
    w_ram_we        = 1'b0;
    w_ram_addr      = bus.fetch_addr;
    w_ram_din       = '0;

    unique case (r_state)
      S_IDLE: begin
        // Fetch reads the RAM directly; a resident program is required.
        w_ram_en      = 1'b1;
        w_fetch_grant = r_prog_valid;
        if (bus.ld_start) begin
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // RAM idle while reads issued before the stall come back.
        if (r_drain_cnt == c_DRAIN_LAST) begin
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        w_ld_ready = 1'b1;
        w_ram_addr = r_wr_ptr[c_ADDR_W-1:0];
        w_ram_din  = bus.ld_data;
        if (bus.ld_valid) begin
          w_ram_en = 1'b1;
          w_ram_we = 1'b1;
          if (bus.ld_last) begin
            w_state_nxt = S_TERM;
          end else if (r_wr_ptr == c_DEPTH_M1) begin
            // RAM full but the program continues.
            w_state_nxt = S_SKIP;
          end
        end
      end

      S_TERM: begin
        // End-of-program marker, unless the program filled the RAM exactly.
        w_ram_addr = r_wr_ptr[c_ADDR_W-1:0];
        if (r_wr_ptr < c_DEPTH) begin
          w_ram_en = 1'b1;
          w_ram_we = 1'b1;
        end
        w_state_nxt = S_DONE;
      end

      S_SKIP: begin
        // Swallow the rest of an oversized program without writing it.
        w_ld_ready = 1'b1;
        if (bus.ld_valid && bus.ld_last) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_fetch_restart = ~r_load_error;
        w_state_nxt     = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Load bookkeeping: drain timer, write pointer, word count, status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prog_valid <= 1'b1;
      r_load_error <= 1'b0;
      r_load_count <= '0;
      r_wr_ptr     <= '0;
      r_drain_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.ld_start) begin
            r_prog_valid <= 1'b0;
            r_load_error <= 1'b0;
            r_load_count <= '0;
            r_wr_ptr     <= '0;
            r_drain_cnt  <= '0;
          end
        end

        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
        end

        S_LOAD: begin
          if (w_xfer) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_load_count <= r_load_count + 1'b1;
            if (bus.ld_last) begin
              if (w_csum_bad) begin
                r_load_error <= 1'b1;
              end
            end else if (r_wr_ptr == c_DEPTH_M1) begin
              r_load_error <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_prog_valid <= ~r_load_error;
        end

        default: begin
        end
      endcase
    end
  end

  assign bus.ld_ready      = w_ld_ready;
  assign bus.fetch_grant   = w_fetch_grant;
  assign bus.fetch_restart = w_fetch_restart;
  assign bus.prog_valid    = r_prog_valid;
  assign bus.load_error    = r_load_error;
  assign bus.load_count    = r_load_count;
  assign bus.ram_en        = w_ram_en;
  assign bus.ram_we        = w_ram_we;
  assign bus.ram_addr      = w_ram_addr;
  assign bus.ram_din       = w_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_inst_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_load_arbiter
//  Description : Randomised program loads against a queue-based model of the
//                expected RAM writes and end-of-load status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_load_arbiter;

  localparam int INST_W = 64;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inst_load_arbiter_if #(.INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  inst_load_arbiter #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  bit  busy        = 1'b0;
  int  grant_viol  = 0;
  int  restart_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stray_write: addr %0d data 0x%0h, none expected", bus.ram_addr, bus.ram_din);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.ram_addr), 64'(e.addr));
          chk("wr_data", bus.ram_din, e.data);
          chk("wr_en", 64'(bus.ram_en), 64'd1);
        end
      end
      if (bus.fetch_restart === 1'b1) restart_cnt++;
      if (busy && (bus.fetch_grant !== 1'b0)) grant_viol++;
    end
  end

  // One program load: builds the expected writes/status, then drives the stream.
  task automatic do_load(input int n, input int gap_mode, input bit bad_csum, input bit mid_start);
    logic [INST_W-1:0] words[$];
    logic [INST_W-1:0] w;
    logic [INST_W-1:0] acc;
    bit ovf, exp_err;
    int exp_cnt, rc0, wait_cnt, first_wait, gaps;
    logic [ADDR_W-1:0] fa;

    acc = '0;
    first_wait = -1;
    ovf = (n > DEPTH);
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      words.push_back(w);
      acc ^= w;
      if (i < DEPTH) exp_q.push_back('{addr: i[ADDR_W-1:0], data: w});
    end
    if (n < DEPTH) exp_q.push_back('{addr: n[ADDR_W-1:0], data: '0});
    exp_cnt = ovf ? DEPTH : n;
    exp_err = ovf;
`ifdef LOAD_CHECKSUM_EN
    if (!ovf && bad_csum) exp_err = 1'b1;
`endif
    rc0 = restart_cnt;

    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    busy = 1'b1;

    for (int i = 0; i < n; i++) begin
      gaps = 0;
      if (i != 0) begin
        if (gap_mode == 1) gaps = 2;
        else if (gap_mode == 2) gaps = $urandom_range(0, 2);
        if (mid_start && (i == 1) && (gaps == 0)) gaps = 1;
      end
      for (int g = 0; g < gaps; g++) begin
        bus.ld_valid = 1'b0;
        bus.ld_start = (mid_start && (i == 1) && (g == 0));
        @(posedge clk); #1;
        bus.ld_start = 1'b0;
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      bus.ld_last  = (i == n - 1);
      bus.ld_csum  = (i == n - 1) ? (bad_csum ? (acc ^ 64'd1) : acc) : {$urandom, $urandom};
      wait_cnt = 0;
      while (1) begin
        @(negedge clk);
        if (bus.ld_ready === 1'b1) break;
        wait_cnt++;
        if (wait_cnt > 50) begin
          n_tests++;
          n_fail++;
          $display("FAIL ready_timeout: word %0d never accepted", i);
          break;
        end
      end
      @(posedge clk); #1;
      if (i == 0) first_wait = wait_cnt;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;

    repeat (ovf ? 1 : 2) @(posedge clk);
    #1;
    busy = 1'b0;

    chk("first_xfer_wait", 64'(first_wait), 64'(RD_LAT));
    chk("restart_pulses", 64'(restart_cnt - rc0), exp_err ? 64'd0 : 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("grant_while_busy", 64'(grant_viol), 64'd0);
    exp_q.delete();

    @(negedge clk);
    chk("prog_valid", 64'(bus.prog_valid), 64'(!exp_err));
    chk("load_error", 64'(bus.load_error), 64'(exp_err));
    chk("load_count", 64'(bus.load_count), 64'(exp_cnt));
    chk("fetch_grant", 64'(bus.fetch_grant), 64'(!exp_err));
    chk("ld_ready_idle", 64'(bus.ld_ready), 64'd0);

    fa = ADDR_W'($urandom);
    bus.fetch_addr = fa;
    #1;
    chk("fetch_ram_addr", 64'(bus.ram_addr), 64'(fa));
    chk("fetch_ram_we", 64'(bus.ram_we), 64'd0);
  endtask

  // Checks the full set of reset values with fetch_addr=5.
  task automatic chk_reset_state(input string tag);
    chk({tag, "_prog_valid"}, 64'(bus.prog_valid), 64'd1);
    chk({tag, "_fetch_grant"}, 64'(bus.fetch_grant), 64'd1);
    chk({tag, "_ld_ready"}, 64'(bus.ld_ready), 64'd0);
    chk({tag, "_restart"}, 64'(bus.fetch_restart), 64'd0);
    chk({tag, "_load_error"}, 64'(bus.load_error), 64'd0);
    chk({tag, "_load_count"}, 64'(bus.load_count), 64'd0);
    chk({tag, "_ram_we"}, 64'(bus.ram_we), 64'd0);
    chk({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'd5);
  endtask

  initial begin
    bus.ld_start   = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    bus.ld_csum    = '0;
    bus.fetch_addr = ADDR_W'(5);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");

    do_load(3, 0, 1'b0, 1'b0);   // basic 3-word program
    do_load(10, 0, 1'b0, 1'b0);  // overflow
    do_load(8, 0, 1'b0, 1'b0);   // exact fill, no terminator
    do_load(7, 1, 1'b0, 1'b1);   // gapped stream with a stray ld_start
    do_load(1, 0, 1'b0, 1'b0);   // single word
    do_load(3, 0, 1'b1, 1'b0);   // checksum mismatch (matters only with checksum)
    do_load(4, 0, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      do_load($urandom_range(1, 11), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a load returns everything to reset values.
    @(posedge clk); #1;
    bus.ld_start = 1'b1;
    @(posedge clk); #1;
    bus.ld_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.fetch_addr = ADDR_W'(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_state("midreset");
    rst_n = 1'b1;

    do_load(2, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
